sram_bus_arbiter: RTL and testbench



---
 rtl/sram_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_bus_arbiter
// Brief   : Round-robin owner of the shared SRAM address/data bus; optional
//           MMIO_OUT_EN macro redirects writes to MMIO_ADDR to the output latch.
// Rev     : 1.0
// ============================================================================
module sram_bus_arbiter #(
  parameter logic [7:0] MMIO_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       ldr_req,
  input  logic       ldr_we,
  input  logic [7:0] ldr_addr,
  input  logic [7:0] ldr_wdata,
  output logic       ldr_ack,
  output logic [7:0] ldr_rdata,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       mem_latch_clk,
  output logic       mem_oe_n,
  output logic       mem_we_n,
  output logic       out_latch_clk,
  output logic       busy,
  output logic       grant
);

`ifdef MMIO_OUT_EN
  localparam logic c_mmio_en = 1'b1;
`else
  localparam logic c_mmio_en = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_LATCH   = 4'd2,
    S_RD_TURN = 4'd3,
    S_RD_OE   = 4'd4,
    S_RD_CAP  = 4'd5,
    S_WR_DATA = 4'd6,
    S_WR_STB  = 4'd7,
    S_ACK     = 4'd8
  } state_t;

  state_t     state_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       we_q;
  logic       grant_q;
  logic [7:0] cpu_rdata_q;
  logic [7:0] ldr_rdata_q;
  logic       grant_d;
  logic       mmio_hit;

  // On a tie the requester that did not own the previous transaction wins.
  assign grant_d  = (cpu_req && ldr_req) ? ~grant_q : ldr_req;
  assign mmio_hit = c_mmio_en && (addr_q == MMIO_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      grant_q     <= 1'b1;
      cpu_rdata_q <= 8'h00;
      ldr_rdata_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req || ldr_req) begin
            grant_q <= grant_d;
            addr_q  <= grant_d ? ldr_addr  : cpu_addr;
            wdata_q <= grant_d ? ldr_wdata : cpu_wdata;
            we_q    <= grant_d ? ldr_we    : cpu_we;
            state_q <= S_ADDR;
          end
        end
        S_ADDR:    state_q <= S_LATCH;
        S_LATCH:   state_q <= we_q ? S_WR_DATA : S_RD_TURN;
        S_RD_TURN: state_q <= S_RD_OE;
        S_RD_OE:   state_q <= S_RD_CAP;
        S_RD_CAP: begin
          if (grant_q) ldr_rdata_q <= bus_in;
          else         cpu_rdata_q <= bus_in;
          state_q <= S_ACK;
        end
        S_WR_DATA: state_q <= S_WR_STB;
        S_WR_STB:  state_q <= S_ACK;
        S_ACK:     state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Pins are a pure decode of the state so reset clears them without a clock.
  always_comb begin
    bus_out       = 8'h00;
    bus_oe        = 1'b0;
    mem_latch_clk = 1'b0;
    mem_oe_n      = 1'b1;
    mem_we_n      = 1'b1;
    out_latch_clk = 1'b0;
    case (state_q)
      S_ADDR: begin
        bus_out = addr_q;
        bus_oe  = 1'b1;
      end
      S_LATCH: begin
        bus_out       = addr_q;
        bus_oe        = 1'b1;
        mem_latch_clk = 1'b1;
      end
      S_RD_TURN: mem_latch_clk = 1'b1;
      S_RD_OE, S_RD_CAP: begin
        mem_latch_clk = 1'b1;
        mem_oe_n      = 1'b0;
      end
      S_WR_DATA: begin
        bus_out       = wdata_q;
        bus_oe        = 1'b1;
        mem_latch_clk = 1'b1;
      end
      S_WR_STB: begin
        bus_out       = wdata_q;
        bus_oe        = 1'b1;
        mem_latch_clk = 1'b1;
        mem_we_n      = mmio_hit;
        out_latch_clk = mmio_hit;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign grant     = grant_q;
  assign cpu_ack   = (state_q == S_ACK) && !grant_q;
  assign ldr_ack   = (state_q == S_ACK) &&  grant_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// Testbench for sram_bus_arbiter: directed and random transactions against an
// external SRAM model, checked against a reference memory and the phase timing.
module tb_sram_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
  logic       ldr_req = 1'b0, ldr_we = 1'b0;
  logic [7:0] ldr_addr = 8'h00, ldr_wdata = 8'h00;
  logic       cpu_ack, ldr_ack;
  logic [7:0] cpu_rdata, ldr_rdata;
  logic [7:0] bus_in, bus_out;
  logic       bus_oe, mem_latch_clk, mem_oe_n, mem_we_n, out_latch_clk, busy, grant;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MMIO_OUT_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  always #5 clk = ~clk;

  sram_bus_arbiter #(.MMIO_ADDR(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .mem_latch_clk(mem_latch_clk), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .out_latch_clk(out_latch_clk), .busy(busy), .grant(grant)
  );

  // External SRAM + address latch model
  logic [7:0] sram    [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rd  [2];
  logic [7:0] lat = 8'h00;

  always @(posedge mem_latch_clk) lat <= bus_out;
  always @(negedge clk) if (mem_we_n === 1'b0) sram[lat] <= bus_out;
  assign bus_in = (mem_oe_n === 1'b0) ? sram[lat] : 8'hEE;

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (!port) begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end
  endtask

  // One isolated transaction; every cycle is checked against the phase table
  // (ADDR, LATCH, then WR_DATA/WR_STB or RD_TURN/RD_OE/RD_CAP, then ACK).
  task automatic run_txn(input bit port, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit scramble);
    int len;
    bit hit, e_oe, e_lclk, e_oen, e_wen, e_olc;
    len = we ? 5 : 6;
    hit = MMIO && we && (addr == 8'hFF);
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1 && scramble) drive(port, 1'b1, we, ~addr, ~wdata);
      e_oe   = (k <= 2) || (we && k < len);
      e_lclk = (k >= 2) && (k < len);
      e_oen  = !(!we && (k == 4 || k == 5));
      e_wen  = !(we && k == 4 && !hit);
      e_olc  = we && k == 4 && hit;
      chk1("ph_bus_oe", bus_oe, e_oe);
      chk1("ph_latch_clk", mem_latch_clk, e_lclk);
      chk1("ph_oe_n", mem_oe_n, e_oen);
      chk1("ph_we_n", mem_we_n, e_wen);
      chk1("ph_out_latch", out_latch_clk, e_olc);
      if (e_oe) chk8("ph_bus_out", bus_out, (k <= 2) ? addr : wdata);
      chk1("ph_busy", busy, 1'b1);
      chk1("ph_grant", grant, port);
      chk1("ph_cpu_ack", cpu_ack, (k == len) && !port);
      chk1("ph_ldr_ack", ldr_ack, (k == len) && port);
    end
    if (!we) exp_rd[port] = ref_mem[addr];
    else if (!hit) ref_mem[addr] = wdata;
    chk8("ack_own_rdata", port ? ldr_rdata : cpu_rdata, exp_rd[port]);
    chk8("ack_other_rdata", port ? cpu_rdata : ldr_rdata, exp_rd[!port]);
    drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_acks", cpu_ack | ldr_ack, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk1("inv_oe_overlap", bus_oe & ~mem_oe_n, 1'b0);
      chk1("inv_we_window", ~mem_we_n & ~(mem_latch_clk & bus_oe), 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, b, d;
    bit ack_seen;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk8("rst_bus_out", bus_out, 8'h00);
    chk1("rst_bus_oe", bus_oe, 1'b0);
    chk1("rst_latch_clk", mem_latch_clk, 1'b0);
    chk1("rst_oe_n", mem_oe_n, 1'b1);
    chk1("rst_we_n", mem_we_n, 1'b1);
    chk1("rst_out_latch", out_latch_clk, 1'b0);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_ldr_ack", ldr_ack, 1'b0);
    chk8("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk8("rst_ldr_rdata", ldr_rdata, 8'h00);
    chk1("rst_grant", grant, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Directed: core write/read, MMIO address, loader field change after capture
    run_txn(1'b0, 1'b1, 8'h10, 8'h5A, 1'b0);
    run_txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    chk8("core_read_5a", cpu_rdata, 8'h5A);
    run_txn(1'b0, 1'b1, 8'hFF, 8'hAA, 1'b0);
    run_txn(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
    run_txn(1'b1, 1'b1, 8'h33, 8'hC3, 1'b1);
    run_txn(1'b1, 1'b0, 8'h33, 8'h00, 1'b1);
    chk8("ldr_captured_addr", ldr_rdata, 8'hC3);

    // Reset asserted during WR_STB
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h44, 8'h99);
    repeat (4) @(posedge clk);
    #1;
    chk1("pre_rst_we_n", mem_we_n, 1'b0);
    reset = 1'b1;
    #1;
    chk1("arst_we_n", mem_we_n, 1'b1);
    chk1("arst_bus_oe", bus_oe, 1'b0);
    chk1("arst_latch_clk", mem_latch_clk, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_grant", grant, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    ack_seen = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (cpu_ack || ldr_ack) ack_seen = 1'b1;
    end
    chk1("arst_no_ack", ack_seen, 1'b0);
    reset = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    run_txn(1'b0, 1'b0, 8'h44, 8'h00, 1'b0);
    run_txn(1'b1, 1'b1, 8'h45, 8'h12, 1'b0);

    // Continuous contention from reset: core writes, loader reads, alternating
    reset = 1'b1;
    a = 8'($urandom_range(0, 15));
    d = 8'($urandom);
    b = 8'($urandom_range(0, 15));
    drive(1'b0, 1'b1, 1'b1, a, d);
    drive(1'b1, 1'b1, 1'b0, b, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    for (int g = 0; g < 6; g++) begin
      int since;
      bit got;
      since = 0;
      got = 1'b0;
      while (!got && since < 12) begin
        @(negedge clk);
        since++;
        got = cpu_ack | ldr_ack;
      end
      chk1("tie_ack_seen", got, 1'b1);
      chk1("tie_owner", ldr_ack, 1'(g % 2));
      chk1("tie_grant", grant, 1'(g % 2));
      chk8("tie_gap", 8'(since), (g == 0) ? 8'd5 : ((g % 2) != 0 ? 8'd7 : 8'd6));
      if (ldr_ack) begin
        chk8("tie_ldr_rdata", ldr_rdata, ref_mem[b]);
        exp_rd[1] = ref_mem[b];
        b = 8'($urandom_range(0, 15));
        drive(1'b1, 1'b1, 1'b0, b, 8'h00);
      end else if (cpu_ack) begin
        ref_mem[a] = d;
        a = 8'($urandom_range(0, 15));
        d = 8'($urandom);
        drive(1'b0, 1'b1, 1'b1, a, d);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("tie_end_idle", busy, 1'b0);

    // Random isolated transactions against the reference memory
    for (int i = 0; i < 30; i++) begin
      bit p, w, s;
      logic [7:0] ad;
      p  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      run_txn(p, w, ad, 8'($urandom), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
